// File: rtl/mem_s_responder_if.sv
// Request/response handshake bundle for mem_s_responder.
// The request word is packed as {wr, data[7:0], addr[7:0]}.
interface mem_s_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [16:0] req_word;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_word, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_word, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_s_responder.sv
// Executes packed mem_s requests against a DEPTH x 8 register array, one response per request.
// Defining MEM_S_STATS_EN adds saturating wr_count/rd_count/err_count outputs.
//
// state   | meaning
// S_EMPTY | no response held; a request is accepted whenever one is offered
// S_FULL  | response held in rsp_data/rsp_err; it is replaced only on the edge it is taken
module mem_s_responder #(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_s_responder_if.slave   bus
`ifdef MEM_S_STATS_EN
    ,
    output logic [15:0]        wr_count,
    output logic [15:0]        rd_count,
    output logic [15:0]        err_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            req_ready;
    logic            accept;
    logic            wr;
    logic [7:0]      wdata;
    logic [7:0]      addr;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      rsp_data;
    logic            rsp_err;

    assign wr       = bus.req_word[16];
    assign wdata    = bus.req_word[15:8];
    assign addr     = bus.req_word[7:0];
    assign in_range = ({1'b0, addr} < 9'(DEPTH));
    assign idx      = addr[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // The slot can be refilled on the same edge its current response is taken.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b1;
        case (state)
            S_EMPTY: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                req_ready = bus.rsp_ready;
                if (bus.rsp_ready && !bus.req_valid) begin
                    state_nxt = S_EMPTY;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
        accept = bus.req_valid && req_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (accept && wr && in_range) begin
            mem[idx] <= wdata;
        end
    end

    // Reads return the array contents from before the edge; writes and errors return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= 8'h00;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_err  <= !in_range;
            rsp_data <= (in_range && !wr) ? mem[idx] : 8'h00;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state == S_FULL);
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;

`ifdef MEM_S_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count  <= 16'h0000;
            rd_count  <= 16'h0000;
            err_count <= 16'h0000;
        end else if (accept) begin
            if (!in_range) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
            end else if (wr) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'h0001;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_s_responder.sv
// Scoreboard bench for mem_s_responder: directed scenarios followed by randomized traffic.
// Counter checks are compiled in when MEM_S_STATS_EN is defined.
module tb_mem_s_responder;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_s_responder_if bus ();

`ifdef MEM_S_STATS_EN
    logic [15:0] wr_count, rd_count, err_count;
`endif

    mem_s_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef MEM_S_STATS_EN
        ,
        .wr_count  (wr_count),
        .rd_count  (rd_count),
        .err_count (err_count)
`endif
    );

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];
    logic [7:0] model [256];
    int   m_wr, m_rd, m_err;
    int   run, max_run;
    bit   rnd_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        m_wr = 0; m_rd = 0; m_err = 0;
    endfunction

    // Reference behaviour: decode the word and act on a plain array.
    function automatic rsp_t model_apply(input logic [16:0] w);
        rsp_t r;
        int a = int'(w[7:0]);
        if (a >= DEPTH) begin
            m_err++;
            r = '{err: 1'b1, data: 8'h00};
        end else if (w[16]) begin
            model[a] = w[15:8];
            m_wr++;
            r = '{err: 1'b0, data: 8'h00};
        end else begin
            m_rd++;
            r = '{err: 1'b0, data: model[a]};
        end
        return r;
    endfunction

    // Monitor: handshakes seen at the negedge are the ones that complete at the next posedge.
    always @(negedge clk) begin
        logic xfer;
        if (!rst) begin
            check("req_ready", 32'(bus.req_ready), 32'((exp_q.size() == 0) || bus.rsp_ready));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
            if (bus.rsp_valid && exp_q.size() != 0) begin
                check("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
                check("rsp_err",  32'(bus.rsp_err),  32'(exp_q[0].err));
            end
            xfer = bus.rsp_valid && bus.rsp_ready;
            if (xfer && exp_q.size() != 0) void'(exp_q.pop_front());
            run = xfer ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (bus.req_valid && bus.req_ready) exp_q.push_back(model_apply(bus.req_word));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic wr, input logic [7:0] d, input logic [7:0] a);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_word  = {wr, d, a};
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got req_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0 || bus.rsp_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_req_ready", 32'(bus.req_ready), 32'(1));
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_word  = '0;
        bus.rsp_ready = 1'b1;
        rnd_ready     = 1'b0;
        run           = 0;
        max_run       = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("reset_rsp_data",  32'(bus.rsp_data),  32'(0));
        check("reset_rsp_err",   32'(bus.rsp_err),   32'(0));
        check("reset_req_ready", 32'(bus.req_ready), 32'(1));
        rst = 1'b0;

        // write then read
        send(1'b1, 8'hFF, 8'h05);
        check("wr_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        check("wr_rsp_data",  32'(bus.rsp_data),  32'(8'h00));
        send(1'b0, 8'h00, 8'h05);
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        check("rd_rsp_data",  32'(bus.rsp_data),  32'(8'hFF));
        drain();

        // out of range write leaves storage untouched
        do_reset();
        send(1'b1, 8'hAA, 8'h08);
        check("oor_err",  32'(bus.rsp_err),  32'(1));
        check("oor_data", 32'(bus.rsp_data), 32'(0));
        for (int i = 0; i < DEPTH; i++) begin
            send(1'b0, 8'h00, 8'(i));
            check("oor_readback", 32'(bus.rsp_data), 32'(0));
        end
        drain();

        // backpressure holds the response and blocks the waiting request
        send(1'b1, 8'h80, 8'h03);
        drain();
        bus.rsp_ready = 1'b0;
        send(1'b0, 8'h00, 8'h03);
        fork
            send(1'b1, 8'h33, 8'h04);
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'(1));
            check("bp_data",  32'(bus.rsp_data),  32'(8'h80));
            check("bp_ready", 32'(bus.req_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.req_ready), 32'(1));
        @(posedge clk);
        #1;
        check("bp_next_valid", 32'(bus.rsp_valid), 32'(1));
        check("bp_next_data",  32'(bus.rsp_data),  32'(0));
        wait fork;
        drain();

        // back-to-back streaming
        max_run = 0;
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h10 + i), 8'(i));
        for (int i = 0; i < 8; i++) send(1'b0, 8'h00, 8'(i));
        drain();
        check("stream_run", 32'(max_run), 32'(16));

        // reset while a response is pending
        bus.rsp_ready = 1'b0;
        send(1'b1, 8'h55, 8'h02);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'(0));
        check("mid_rst_ready", 32'(bus.req_ready), 32'(1));
        exp_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        send(1'b0, 8'h00, 8'h02);
        check("mid_rst_read", 32'(bus.rsp_data), 32'(0));
        drain();

`ifdef MEM_S_STATS_EN
        do_reset();
        send(1'b1, 8'h01, 8'h00);
        send(1'b1, 8'h02, 8'h01);
        send(1'b1, 8'h03, 8'h02);
        send(1'b0, 8'h00, 8'h00);
        send(1'b0, 8'h00, 8'h01);
        send(1'b1, 8'h04, 8'hF0);
        drain();
        check("stats_wr",  32'(wr_count),  32'(3));
        check("stats_rd",  32'(rd_count),  32'(2));
        check("stats_err", 32'(err_count), 32'(1));
`endif

        // randomized traffic with random consumer backpressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            logic       w;
            logic [7:0] d, a;
            w = ($urandom_range(0, 1) == 1);
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(DEPTH, 255));
            else                           a = 8'($urandom_range(0, DEPTH - 1));
            send(w, d, a);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd_ready = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

`ifdef MEM_S_STATS_EN
        check("rand_stats_wr",  32'(wr_count),  32'(m_wr));
        check("rand_stats_rd",  32'(rd_count),  32'(m_rd));
        check("rand_stats_err", 32'(err_count), 32'(m_err));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2000000");
        $fatal(1, "timeout");
    end
endmodule
